vram_arbiter: RTL and testbench

Arbitrates a single-port synchronous video RAM between the display scan-out path of the 1280x720 VGA timing generator and a CPU-side requester. Display pixel fetches issued on each active-area pixel strobe have absolute priority and fixed latency. The CPU is served in the remaining clock cycles through a 4-phase req/ack handshake. The block sits between the timing generator/pixel pipeline, the CPU bus bridge and the VRAM macro.

---
 rtl/vram_arb_pkg.sv | 10 +
 rtl/vram_rd_pipe.sv | 47 ++++
 rtl/vram_arbiter.sv | 125 ++++++++++++
 tb/tb_vram_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_arb_pkg.sv
// Shared types and default widths for the VRAM display/CPU arbiter.
package vram_arb_pkg;

   localparam int ADDR_W_DFLT = 16;
   localparam int DATA_W_DFLT = 8;

   typedef enum logic [1:0] {IDLE, PEND, BUSY, WAITLO} cpu_state_t;
   typedef enum logic [1:0] {TAG_NONE, TAG_DISP, TAG_CPU} tag_t;

endpackage

// File: rtl/vram_rd_pipe.sv
// Two-stage tag pipe following each RAM command; steers the returning read data
// to the display or CPU output registers and produces the valid/ack pulses.
module vram_rd_pipe
   import vram_arb_pkg::*;
#(
   parameter int DATA_W = DATA_W_DFLT
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  tag_t              i_tag,
   input  logic              i_cpu_rd,
   input  logic [DATA_W-1:0] i_mem_rdata,
   output logic [DATA_W-1:0] o_disp_data,
   output logic              o_disp_valid,
   output logic [DATA_W-1:0] o_cpu_rdata,
   output logic              o_cpu_ack
);

   tag_t tag_q1, tag_q2;
   logic rd_q1, rd_q2;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         tag_q1       <= TAG_NONE;
         tag_q2       <= TAG_NONE;
         rd_q1        <= 1'b0;
         rd_q2        <= 1'b0;
         o_disp_data  <= '0;
         o_disp_valid <= 1'b0;
         o_cpu_rdata  <= '0;
         o_cpu_ack    <= 1'b0;
      end else begin
         tag_q1       <= i_tag;
         rd_q1        <= i_cpu_rd;
         tag_q2       <= tag_q1;
         rd_q2        <= rd_q1;
         o_disp_valid <= (tag_q2 == TAG_DISP);
         o_cpu_ack    <= (tag_q2 == TAG_CPU);
         if (tag_q2 == TAG_DISP)
            o_disp_data <= i_mem_rdata;
         // Writes complete with an ack but leave the last read data untouched.
         if (tag_q2 == TAG_CPU && rd_q2)
            o_cpu_rdata <= i_mem_rdata;
      end
   end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: active-area pixel fetches win every slot, the CPU uses the rest.
// Build option VRAM_ARB_BLANK_ONLY_EN restricts CPU commands to cycles with i_active low.
module vram_arbiter
   import vram_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DFLT,
   parameter int DATA_W = DATA_W_DFLT
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_pix_stb,
   input  logic              i_active,
   input  logic [ADDR_W-1:0] i_disp_addr,
   output logic [DATA_W-1:0] o_disp_data,
   output logic              o_disp_valid,
   input  logic              i_cpu_req,
   input  logic              i_cpu_we,
   input  logic [ADDR_W-1:0] i_cpu_addr,
   input  logic [DATA_W-1:0] i_cpu_wdata,
   output logic              o_cpu_ack,
   output logic [DATA_W-1:0] o_cpu_rdata,
   output logic              o_mem_en,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_wdata,
   input  logic [DATA_W-1:0] i_mem_rdata
);

   cpu_state_t        state;
   logic              cpu_we_q;
   logic [ADDR_W-1:0] cpu_addr_q;
   logic [DATA_W-1:0] cpu_wdata_q;

   logic              disp_issue;
   logic              cpu_pend;
   logic              cpu_slot;
   logic              cpu_issue;
   logic              cmd_we;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;
   tag_t              cmd_tag;

   assign disp_issue = i_pix_stb & i_active;
   // A request seen in IDLE counts as accepted this cycle, so it may issue immediately.
   assign cpu_pend   = (state == PEND) | ((state == IDLE) & i_cpu_req);

`ifdef VRAM_ARB_BLANK_ONLY_EN
   assign cpu_slot   = ~i_active;
`else
   assign cpu_slot   = 1'b1;
`endif

   assign cpu_issue  = cpu_pend & ~disp_issue & cpu_slot;

   always_comb begin
      cmd_we    = 1'b0;
      cmd_addr  = '0;
      cmd_wdata = '0;
      cmd_tag   = TAG_NONE;
      if (disp_issue) begin
         cmd_addr = i_disp_addr;
         cmd_tag  = TAG_DISP;
      end else if (cpu_issue) begin
         cmd_tag = TAG_CPU;
         if (state == PEND) begin
            cmd_we    = cpu_we_q;
            cmd_addr  = cpu_addr_q;
            cmd_wdata = cpu_wdata_q;
         end else begin
            cmd_we    = i_cpu_we;
            cmd_addr  = i_cpu_addr;
            cmd_wdata = i_cpu_wdata;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state       <= IDLE;
         cpu_we_q    <= 1'b0;
         cpu_addr_q  <= '0;
         cpu_wdata_q <= '0;
      end else begin
         case (state)
            IDLE: if (i_cpu_req) begin
               cpu_we_q    <= i_cpu_we;
               cpu_addr_q  <= i_cpu_addr;
               cpu_wdata_q <= i_cpu_wdata;
               state       <= cpu_issue ? BUSY : PEND;
            end
            PEND:    if (cpu_issue) state <= BUSY;
            BUSY:    if (o_cpu_ack) state <= WAITLO;
            WAITLO:  if (!i_cpu_req) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_mem_en    <= 1'b0;
         o_mem_we    <= 1'b0;
         o_mem_addr  <= '0;
         o_mem_wdata <= '0;
      end else begin
         o_mem_en    <= disp_issue | cpu_issue;
         o_mem_we    <= cmd_we;
         o_mem_addr  <= cmd_addr;
         o_mem_wdata <= cmd_wdata;
      end
   end

   vram_rd_pipe #(.DATA_W(DATA_W)) u_rd_pipe (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_tag        (cmd_tag),
      .i_cpu_rd     (cpu_issue & ~cmd_we),
      .i_mem_rdata  (i_mem_rdata),
      .o_disp_data  (o_disp_data),
      .o_disp_valid (o_disp_valid),
      .o_cpu_rdata  (o_cpu_rdata),
      .o_cpu_ack    (o_cpu_ack)
   );

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a one-cycle-latency behavioural VRAM.
module tb_vram_arbiter;

   logic        i_clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic        i_pix_stb = 1'b0;
   logic        i_active = 1'b0;
   logic [15:0] i_disp_addr = '0;
   logic [7:0]  o_disp_data;
   logic        o_disp_valid;
   logic        i_cpu_req = 1'b0;
   logic        i_cpu_we = 1'b0;
   logic [15:0] i_cpu_addr = '0;
   logic [7:0]  i_cpu_wdata = '0;
   logic        o_cpu_ack;
   logic [7:0]  o_cpu_rdata;
   logic        o_mem_en;
   logic        o_mem_we;
   logic [15:0] o_mem_addr;
   logic [7:0]  o_mem_wdata;
   logic [7:0]  i_mem_rdata;

   logic [7:0]  mem [0:65535];
   int          checks = 0;
   int          errors = 0;

   always #5 i_clk = ~i_clk;

   vram_arbiter dut (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_pix_stb    (i_pix_stb),
      .i_active     (i_active),
      .i_disp_addr  (i_disp_addr),
      .o_disp_data  (o_disp_data),
      .o_disp_valid (o_disp_valid),
      .i_cpu_req    (i_cpu_req),
      .i_cpu_we     (i_cpu_we),
      .i_cpu_addr   (i_cpu_addr),
      .i_cpu_wdata  (i_cpu_wdata),
      .o_cpu_ack    (o_cpu_ack),
      .o_cpu_rdata  (o_cpu_rdata),
      .o_mem_en     (o_mem_en),
      .o_mem_we     (o_mem_we),
      .o_mem_addr   (o_mem_addr),
      .o_mem_wdata  (o_mem_wdata),
      .i_mem_rdata  (i_mem_rdata)
   );

   // RAM model: preload while reset is low, read data one cycle after the command.
   always @(posedge i_clk) begin
      if (!i_rst_n) begin
         for (int k = 0; k < 4; k++)
            mem[16'h0100 + k] <= 8'hA0 + 8'(k);
      end else if (o_mem_en) begin
         if (o_mem_we)
            mem[o_mem_addr] <= o_mem_wdata;
         else
            i_mem_rdata <= mem[o_mem_addr];
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge i_clk);
      #1;
   endtask

   task automatic cpu_release;
      i_cpu_req = 1'b0;
      tick();
      chk("ack_single", o_cpu_ack, 0);
      tick();
   endtask

   initial begin
      i_mem_rdata = '0;
      tick();
      tick();
      chk("rst_mem_en",   o_mem_en, 0);
      chk("rst_mem_we",   o_mem_we, 0);
      chk("rst_mem_addr", o_mem_addr, 0);
      chk("rst_disp_vld", o_disp_valid, 0);
      chk("rst_disp_dat", o_disp_data, 0);
      chk("rst_ack",      o_cpu_ack, 0);
      chk("rst_rdata",    o_cpu_rdata, 0);
      i_rst_n = 1'b1;
      tick();

      // Display fetches, one strobe every 4 cycles.
      i_active = 1'b1;
      for (int i = 0; i < 4; i++) begin
         i_pix_stb   = 1'b1;
         i_disp_addr = 16'h0100 + 16'(i);
         tick();
         i_pix_stb = 1'b0;
         chk("disp_cmd_en",   o_mem_en, 1);
         chk("disp_cmd_addr", o_mem_addr, 16'h0100 + i);
         chk("disp_cmd_we",   o_mem_we, 0);
         chk("disp_vld_t1",   o_disp_valid, 0);
         tick();
         chk("disp_vld_t2",   o_disp_valid, 0);
         tick();
         chk("disp_vld_t3",   o_disp_valid, 1);
         chk("disp_data",     o_disp_data, 8'hA0 + i);
         tick();
      end
      i_active = 1'b0;
      chk("disp_vld_t4", o_disp_valid, 0);
      tick();

      // CPU write then read-back.
      i_cpu_req = 1'b1; i_cpu_we = 1'b1; i_cpu_addr = 16'h2000; i_cpu_wdata = 8'h55;
      tick();
      chk("wr_cmd_en",    o_mem_en, 1);
      chk("wr_cmd_we",    o_mem_we, 1);
      chk("wr_cmd_addr",  o_mem_addr, 16'h2000);
      chk("wr_cmd_wdata", o_mem_wdata, 8'h55);
      chk("wr_ack_t1",    o_cpu_ack, 0);
      i_cpu_addr = 16'hFFFF; i_cpu_wdata = 8'hAA;
      tick();
      chk("wr_we_once",   o_mem_we, 0);
      chk("wr_en_once",   o_mem_en, 0);
      chk("wr_ack_t2",    o_cpu_ack, 0);
      tick();
      chk("wr_ack_t3",    o_cpu_ack, 1);
      chk("wr_rdata_keep", o_cpu_rdata, 0);
      cpu_release();

      i_cpu_req = 1'b1; i_cpu_we = 1'b0; i_cpu_addr = 16'h2000;
      tick();
      chk("rd_cmd_en",   o_mem_en, 1);
      chk("rd_cmd_we",   o_mem_we, 0);
      chk("rd_cmd_addr", o_mem_addr, 16'h2000);
      tick();
      chk("rd_ack_t2",   o_cpu_ack, 0);
      tick();
      chk("rd_ack_t3",   o_cpu_ack, 1);
      chk("rd_rdata",    o_cpu_rdata, 8'h55);
      cpu_release();

      // Collision: strobe and CPU request in the same cycle.
      i_active = 1'b1; i_pix_stb = 1'b1; i_disp_addr = 16'h0102;
      i_cpu_req = 1'b1; i_cpu_we = 1'b0; i_cpu_addr = 16'h0101;
      tick();
      i_pix_stb = 1'b0; i_cpu_addr = 16'h2000;
      chk("col_disp_first", o_mem_addr, 16'h0102);
      chk("col_en1",        o_mem_en, 1);
      tick();
      chk("col_cpu_next",   o_mem_addr, 16'h0101);
      chk("col_en2",        o_mem_en, 1);
      tick();
      chk("col_disp_vld",   o_disp_valid, 1);
      chk("col_disp_data",  o_disp_data, 8'hA2);
      chk("col_ack_t3",     o_cpu_ack, 0);
      tick();
      chk("col_ack_t4",     o_cpu_ack, 1);
      chk("col_rdata",      o_cpu_rdata, 8'hA1);
      chk("col_vld_t4",     o_disp_valid, 0);
      cpu_release();

      // Blank-area strobe: no fetch, CPU takes the slot.
      i_active = 1'b0; i_pix_stb = 1'b1; i_disp_addr = 16'h0100;
      i_cpu_req = 1'b1; i_cpu_we = 1'b0; i_cpu_addr = 16'h0103;
      tick();
      i_pix_stb = 1'b0;
      chk("blk_cpu_addr", o_mem_addr, 16'h0103);
      chk("blk_en",       o_mem_en, 1);
      tick();
      chk("blk_vld_t2",   o_disp_valid, 0);
      tick();
      chk("blk_vld_t3",   o_disp_valid, 0);
      chk("blk_ack",      o_cpu_ack, 1);
      chk("blk_rdata",    o_cpu_rdata, 8'hA3);
      cpu_release();

      // CPU request during the active area without strobes.
      i_active = 1'b1;
      i_cpu_req = 1'b1; i_cpu_we = 1'b0; i_cpu_addr = 16'h0100;
`ifdef VRAM_ARB_BLANK_ONLY_EN
      tick();
      chk("bo_hold1", o_mem_en, 0);
      tick();
      chk("bo_hold2", o_mem_en, 0);
      i_active = 1'b0;
      tick();
      chk("bo_en",    o_mem_en, 1);
      chk("bo_addr",  o_mem_addr, 16'h0100);
      tick();
      chk("bo_ack_t2", o_cpu_ack, 0);
      tick();
`else
      tick();
      chk("act_en",   o_mem_en, 1);
      chk("act_addr", o_mem_addr, 16'h0100);
      tick();
      chk("act_ack_t2", o_cpu_ack, 0);
      tick();
`endif
      chk("act_ack",   o_cpu_ack, 1);
      chk("act_rdata", o_cpu_rdata, 8'hA0);
      i_active = 1'b0;
      cpu_release();

      // Reset one cycle after a CPU read issues.
      i_cpu_req = 1'b1; i_cpu_we = 1'b0; i_cpu_addr = 16'h0102;
      tick();
      chk("rr_issue", o_mem_en, 1);
      i_rst_n = 1'b0;
      #1;
      chk("rr_en0",    o_mem_en, 0);
      chk("rr_addr0",  o_mem_addr, 0);
      chk("rr_ack0",   o_cpu_ack, 0);
      chk("rr_rdata0", o_cpu_rdata, 0);
      chk("rr_vld0",   o_disp_valid, 0);
      chk("rr_dat0",   o_disp_data, 0);
      i_cpu_req = 1'b0;
      tick();
      tick();
      i_rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rr_no_ack", o_cpu_ack, 0);
         chk("rr_no_vld", o_disp_valid, 0);
      end
      i_cpu_req = 1'b1; i_cpu_we = 1'b0; i_cpu_addr = 16'h0101;
      tick();
      chk("rr_new_en",   o_mem_en, 1);
      chk("rr_new_addr", o_mem_addr, 16'h0101);
      tick();
      tick();
      chk("rr_new_ack",   o_cpu_ack, 1);
      chk("rr_new_rdata", o_cpu_rdata, 8'hA1);
      cpu_release();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
